// File: rtl/exe_stage_mdu_if.sv
// Execute-stage bundle: ID/EX inputs, forwarding sources and the registered EX/MEM outputs.
// master drives the E-stage side, slave is the execute stage itself.
interface exe_stage_mdu_if #(
  parameter int XLEN = 64
);
  logic            valid_e, flush_e;
  logic [3:0]      alu_op_e;
  logic [1:0]      md_op_e;
  logic            alu_src_e;
  logic [XLEN-1:0] rd1_e, rd2_e, imm_e, pc_e;
  logic [4:0]      rs1_e, rs2_e, rd_e;
  logic            reg_write_e, mem_write_e, mem_to_reg_e;
  logic            beq_e, bne_e, jal_e, jalr_e;
  logic [4:0]      rd_m, rd_w;
  logic            reg_write_m, reg_write_w;
  logic [XLEN-1:0] alu_result_m, write_data_w;
  logic            pc_src_e;
  logic [XLEN-1:0] pc_target_e;
  logic            stall_e;
  logic            valid_m, reg_write_m_out, mem_write_m_out, mem_to_reg_m_out;
  logic [4:0]      rd_m_out;
  logic [XLEN-1:0] write_data_m_out, alu_result_m_out;

  modport master (
    output valid_e, flush_e, alu_op_e, md_op_e, alu_src_e, rd1_e, rd2_e, imm_e, pc_e,
           rs1_e, rs2_e, rd_e, reg_write_e, mem_write_e, mem_to_reg_e,
           beq_e, bne_e, jal_e, jalr_e, rd_m, rd_w, reg_write_m, reg_write_w,
           alu_result_m, write_data_w,
    input  pc_src_e, pc_target_e, stall_e, valid_m, reg_write_m_out, mem_write_m_out,
           mem_to_reg_m_out, rd_m_out, write_data_m_out, alu_result_m_out
  );

  modport slave (
    input  valid_e, flush_e, alu_op_e, md_op_e, alu_src_e, rd1_e, rd2_e, imm_e, pc_e,
           rs1_e, rs2_e, rd_e, reg_write_e, mem_write_e, mem_to_reg_e,
           beq_e, bne_e, jal_e, jalr_e, rd_m, rd_w, reg_write_m, reg_write_w,
           alu_result_m, write_data_w,
    output pc_src_e, pc_target_e, stall_e, valid_m, reg_write_m_out, mem_write_m_out,
           mem_to_reg_m_out, rd_m_out, write_data_m_out, alu_result_m_out
  );
endinterface

// File: rtl/exe_stage_mdu.sv
// Execute stage with forwarding, branch resolution and an iterative MUL/DIVU/REMU unit.
// Optional: define MDU_EARLY_OUT_EN to let MUL finish once the remaining multiplier bits are zero.
module exe_stage_mdu #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  exe_stage_mdu_if.slave bus
);
  localparam int ITER = XLEN / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);
  localparam int SW   = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;
  localparam logic [1:0] MD_MUL  = 2'd1;
  localparam logic [1:0] MD_REMU = 2'd3;

  mdu_state_t      state_p1;
  logic [CW-1:0]   ctr_p1;
  logic [1:0]      op_p1;
  logic [XLEN-1:0] acc_p1, opa_p1, opb_p1, rem_p1;

  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res, ex_res, mdu_res, jalr_sum;
  logic [SW-1:0]   shamt;
  logic            eq, br_en, mdu_launch, capture;
  logic [XLEN-1:0] m_acc, m_a, m_b, d_q, d_rem;
  logic [XLEN:0]   d_r;

  // E stage: forwarding (MEM before WB, x0 never forwarded)
  always_comb begin
    fwd_a = bus.rd1_e;
    if (bus.reg_write_m && bus.rd_m != 5'd0 && bus.rd_m == bus.rs1_e)      fwd_a = bus.alu_result_m;
    else if (bus.reg_write_w && bus.rd_w != 5'd0 && bus.rd_w == bus.rs1_e) fwd_a = bus.write_data_w;
    fwd_b = bus.rd2_e;
    if (bus.reg_write_m && bus.rd_m != 5'd0 && bus.rd_m == bus.rs2_e)      fwd_b = bus.alu_result_m;
    else if (bus.reg_write_w && bus.rd_w != 5'd0 && bus.rd_w == bus.rs2_e) fwd_b = bus.write_data_w;
  end

  assign op_b  = bus.alu_src_e ? bus.imm_e : fwd_b;
  assign shamt = op_b[SW-1:0];

  always_comb begin
    case (bus.alu_op_e)
      4'd0:    alu_res = fwd_a + op_b;
      4'd1:    alu_res = fwd_a - op_b;
      4'd2:    alu_res = fwd_a & op_b;
      4'd3:    alu_res = fwd_a | op_b;
      4'd4:    alu_res = fwd_a ^ op_b;
      4'd5:    alu_res = fwd_a << shamt;
      4'd6:    alu_res = fwd_a >> shamt;
      4'd7:    alu_res = $unsigned($signed(fwd_a) >>> shamt);
      4'd8:    alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      4'd9:    alu_res = {{(XLEN-1){1'b0}}, (fwd_a < op_b)};
      default: alu_res = '0;
    endcase
  end

  assign eq          = (fwd_a == fwd_b);
  assign br_en       = bus.valid_e && !bus.flush_e && (bus.md_op_e == 2'd0);
  assign jalr_sum    = fwd_a + bus.imm_e;
  assign bus.pc_src_e = br_en && ((bus.beq_e && eq) || (bus.bne_e && !eq) || bus.jal_e || bus.jalr_e);
  assign bus.pc_target_e = bus.jalr_e ? (jalr_sum & ~XLEN'(1)) : (bus.pc_e + bus.imm_e);

  // One iteration of shift-add multiply and restoring divide on the latched operands
  always_comb begin
    m_acc = acc_p1;
    m_a   = opa_p1;
    m_b   = opb_p1;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (m_b[0]) m_acc = m_acc + m_a;
      m_a = m_a << 1;
      m_b = m_b >> 1;
    end
    d_q   = acc_p1;
    d_rem = rem_p1;
    d_r   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      d_r = {d_rem, d_q[XLEN-1]};
      d_q = {d_q[XLEN-2:0], 1'b0};
      if (d_r >= {1'b0, opb_p1}) begin
        d_r    = d_r - {1'b0, opb_p1};
        d_q[0] = 1'b1;
      end
      d_rem = d_r[XLEN-1:0];
    end
  end

  assign mdu_launch  = (state_p1 == IDLE) && bus.valid_e && !bus.flush_e && (bus.md_op_e != 2'd0);
  assign bus.stall_e = mdu_launch || (state_p1 == BUSY);
  assign mdu_res     = (op_p1 == MD_REMU) ? rem_p1 : acc_p1;
  assign ex_res      = (state_p1 == DONE) ? mdu_res : alu_res;

  // MDU sequencer; division keeps the dividend/quotient in acc_p1
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1 <= IDLE;
      ctr_p1   <= '0;
      op_p1    <= 2'd0;
    end else if (bus.flush_e) begin
      state_p1 <= IDLE;
    end else begin
      case (state_p1)
        IDLE: if (mdu_launch) begin
          op_p1  <= bus.md_op_e;
          ctr_p1 <= CW'(ITER);
          opa_p1 <= fwd_a;
          opb_p1 <= fwd_b;
          rem_p1 <= '0;
          if (bus.md_op_e == MD_MUL) begin
            acc_p1 <= '0;
`ifdef MDU_EARLY_OUT_EN
            state_p1 <= (fwd_b == '0) ? DONE : BUSY;
`else
            state_p1 <= BUSY;
`endif
          end else if (fwd_b == '0) begin
            acc_p1   <= '1;
            rem_p1   <= fwd_a;
            state_p1 <= DONE;
          end else begin
            acc_p1   <= fwd_a;
            state_p1 <= BUSY;
          end
        end
        BUSY: begin
          ctr_p1 <= ctr_p1 - CW'(1);
          if (op_p1 == MD_MUL) begin
            acc_p1 <= m_acc;
            opa_p1 <= m_a;
            opb_p1 <= m_b;
`ifdef MDU_EARLY_OUT_EN
            if (ctr_p1 == CW'(1) || m_b == '0) state_p1 <= DONE;
`else
            if (ctr_p1 == CW'(1)) state_p1 <= DONE;
`endif
          end else begin
            acc_p1 <= d_q;
            rem_p1 <= d_rem;
            if (ctr_p1 == CW'(1)) state_p1 <= DONE;
          end
        end
        default: state_p1 <= IDLE;
      endcase
    end
  end

  assign capture = bus.valid_e && !bus.flush_e && !bus.stall_e;

  // EX/MEM boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.valid_m          <= 1'b0;
      bus.reg_write_m_out  <= 1'b0;
      bus.mem_write_m_out  <= 1'b0;
      bus.mem_to_reg_m_out <= 1'b0;
      bus.rd_m_out         <= '0;
      bus.write_data_m_out <= '0;
      bus.alu_result_m_out <= '0;
    end else if (capture) begin
      bus.valid_m          <= 1'b1;
      bus.reg_write_m_out  <= bus.reg_write_e;
      bus.mem_write_m_out  <= bus.mem_write_e;
      bus.mem_to_reg_m_out <= bus.mem_to_reg_e;
      bus.rd_m_out         <= bus.rd_e;
      bus.write_data_m_out <= fwd_b;
      bus.alu_result_m_out <= ex_res;
    end else begin
      bus.valid_m          <= 1'b0;
      bus.reg_write_m_out  <= 1'b0;
      bus.mem_write_m_out  <= 1'b0;
    end
  end
endmodule

// File: doc/exe_stage_mdu.md
Name: exe_stage_mdu

Overview:
Parametrised next-generation execute stage for the in-order RISC-V pipeline, sitting between the ID/EX and EX/MEM registers. It adds the following to the existing execute function:
- XLEN generalisation.
- Forwarding that also covers store data.
- A valid/flush/stall pipeline handshake.
- An iterative multiply/divide unit (MUL, DIVU, REMU) that stalls upstream stages while busy.

It resolves branches and jumps and registers all results into the EX/MEM pipeline register.

Parameters:
- XLEN, 64, datapath width; allowed values 32 and 64.
- BITS_PER_CYCLE, 1, multiplier/divider bits retired per iteration; allowed values 1, 2 and 4; ITER = XLEN/BITS_PER_CYCLE.

Ports:
- clk  in  1  clock; all state on the rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_e  in  1  E-stage instruction is valid.
- flush_e  in  1  kill the E-stage instruction (branch redirect).
- alu_op_e  in  4  ALU operation: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu; any other value gives 0.
- md_op_e  in  2  0 none, 1 MUL (low XLEN bits), 2 DIVU, 3 REMU.
- alu_src_e  in  1  operand B is imm_e.
- rd1_e, rd2_e, imm_e, pc_e  in  XLEN  register operands, sign-extended byte-offset immediate, and PC.
- rs1_e, rs2_e, rd_e  in  5  register indices.
- reg_write_e, mem_write_e, mem_to_reg_e, beq_e, bne_e, jal_e, jalr_e  in  1  control signals.
- rd_m, rd_w  in  5  destination registers in MEM and WB.
- reg_write_m, reg_write_w  in  1  write enables in MEM and WB.
- alu_result_m, write_data_w  in  XLEN  forwarding sources.
- pc_src_e  out  1  redirect taken (combinational).
- pc_target_e  out  XLEN  redirect address (combinational).
- stall_e  out  1  hold IF/ID/E (combinational).
- valid_m, reg_write_m_out, mem_write_m_out, mem_to_reg_m_out  out  1  registered M-stage control.
- rd_m_out  out  5  registered destination register.
- write_data_m_out, alu_result_m_out  out  XLEN  registered store data and result.

Behaviour:
Forwarding (rs1 and rs2 independently):
- Forward from MEM if reg_write_m && rd_m!=0 && rd_m==rs.
- Otherwise forward from WB under the same conditions on the WB signals.
- Otherwise use the register-file value.
- MEM has priority over WB. Register x0 is never forwarded.

Operand B and store data:
- The operand-B mux (alu_src_e selects imm_e) is applied after forwarding.
- write_data_m_out takes the forwarded rs2 value.

ALU arithmetic:
- Shift amount = operand B[log2(XLEN)-1:0].
- slt is signed; sltu is unsigned.
- Results wrap modulo 2^XLEN.

Branch and jump resolution (combinational, gated by valid_e && !flush_e && md_op_e==0):
- pc_src_e = beq&&eq | bne&&!eq | jal | jalr, where eq compares the forwarded operands.
- Non-JALR target: pc_target_e = pc_e + imm_e (imm_e is already a byte offset; no shift).
- JALR target: pc_target_e = (fwdA + imm_e) with bit 0 cleared.

MDU state machine (IDLE, BUSY, DONE):
- IDLE: on valid_e && md_op_e!=0 && !flush_e, latch the forwarded operands, load the counter with ITER, assert stall_e, and go to BUSY.
- IDLE, DIVU/REMU with divisor 0: go straight to DONE. Result is all-ones for DIVU and the dividend for REMU.
- BUSY: stall_e=1; perform one BITS_PER_CYCLE step (shift-add multiply or restoring divide) and decrement the counter. When the counter reaches 0, go to DONE.
- DONE: stall_e=0; the MDU result is presented in place of the ALU result. The edge at the end of DONE registers it into M and returns to IDLE.
- Stall length for a normal operation is exactly ITER+1 cycles; for divide-by-zero it is 1 cycle.
- Operands are latched at launch, so forwarding changes during BUSY have no effect.
- flush_e in any state returns the FSM to IDLE on the next edge and drops stall_e on that edge.

Pipeline register:
- If stall_e || flush_e || !valid_e, the next edge inserts a bubble: valid_m, reg_write_m_out and mem_write_m_out go to 0; other fields are don't-care.
- Otherwise all fields are captured and valid_m=1.

Reset:
- Every registered output goes to 0 and the FSM goes to IDLE, including when reset is asserted mid-operation.
- The next operation starts cleanly.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined: a MUL leaves BUSY for DONE as soon as the remaining (shifted) multiplier bits are all zero. A MUL with rs2==0 goes IDLE->DONE directly. Division is unchanged.
- Undefined: every MUL takes the full ITER iterations.

Test Plan:
All scenarios use XLEN=64, BITS_PER_CYCLE=1 (ITER=64).
1. ADD with rs1=5, rd_m=5, reg_write_m=1, alu_result_m=10, rd1=99, rd2=7 -> alu_result_m_out=17, valid_m=1 one edge later.
2. rs2=6 with rd_m=rd_w=6, both writing, alu_result_m=1, write_data_w=2, store -> write_data_m_out=1. Repeat with rs2=0 -> rd2_e is used.
3. MUL 7*6 -> stall_e high 65 cycles, valid_m=0 throughout, then alu_result_m_out=42. With MDU_EARLY_OUT_EN and 7*3 -> stall 3 cycles, result 21.
4. DIVU 100/7 -> 14; REMU -> 2; DIVU 5/0 -> 0xFFFF_FFFF_FFFF_FFFF with stall 1 cycle; REMU 5/0 -> 5.
5. flush_e during BUSY at cycle 10 -> stall_e=0 on the next edge, no valid_m, a following ADD completes normally. Reset in BUSY -> all outputs 0, FSM IDLE.
6. BNE with rs1=rs2=3 -> pc_src_e=0. JALR with rs1=0x1000, imm=0x11 -> pc_target_e=0x1010, pc_src_e=1. BEQ with pc=0x200, imm=-8, equal operands -> target 0x1F8.
